ddr4_cmd_sequencer: RTL and testbench
=====================================

# ddr4_cmd_sequencer

Single-request DDR4 command sequencer between a host request port and the `dimm` model's command/DQ pins. It accepts one read or write burst at a time and issues ACT, RD/WR and PRE with programmable tRCD/tCL/tCWL/tWR/tRP spacing. For writes it drives DQ/DQS for BL beats; for reads it captures BL beats of DQ. It replaces hand-timed command stimulus with a reusable controller.

## Interface
Parameters:
- RANKS, 1, number of chip selects
- BGWIDTH, 2, bank-group address width
- BAWIDTH, 2, bank address width
- ADDRWIDTH, 17, A bus width (row width)
- COLWIDTH, 10, column address width
- DQWIDTH, 72, data width including ECC
- DQSWIDTH, 18, strobe width
- BL, 8, burst length in beats
- TRCD, 15, ACT-to-RD/WR cycles
- TCL, 15, RD-to-first-data cycles
- TCWL, 11, WR-to-first-data cycles
- TWR, 12, last write beat to PRE recovery cycles
- TRP, 15, PRE-to-ready cycles

All timing parameters are ≥1.

Ports:
- ck_t  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_write  in  1  1 = write, 0 = read
- req_rank  in  $clog2(RANKS) (min 1)  rank index
- req_bg  in  BGWIDTH  bank group
- req_ba  in  BAWIDTH  bank
- req_row  in  ADDRWIDTH  row
- req_col  in  COLWIDTH  column
- req_wdata  in  DQWIDTH*BL  write burst; beat i = bits [i*DQWIDTH +: DQWIDTH]
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  DQWIDTH*BL  captured read burst, same beat packing
- cs_n  out  RANKS  chip selects
- act_n  out  1  activate
- A  out  ADDRWIDTH  address/command bus
- bg  out  BGWIDTH
- ba  out  BAWIDTH
- dq_out  out  DQWIDTH  write data beat
- dq_oe  out  1  DQ/DQS drive enable
- dq_in  in  DQWIDTH  read data from DIMM
- dqs_t_out  out  DQSWIDTH
- dqs_c_out  out  DQSWIDTH

## Operation
- FSM states: IDLE, ACT, WAIT_RCD, CMD, WAIT_LAT, BURST, WAIT_WR, PRE, WAIT_RP.
- IDLE: req_ready=1. Handshake completes on req_valid && req_ready. All request fields and req_wdata are latched, then the FSM enters ACT. req_ready is 0 in every other state.
- Command encoding (one cycle per command, cs_n[rank]=0, other ranks 1):
  - ACT: act_n=0, A=row, bg/ba=request.
  - WR: act_n=1, A[16:14]=3'b100, A[COLWIDTH-1:0]=col, other A bits 0.
  - RD: act_n=1, A[16:14]=3'b101, column in A as for WR.
  - PRE: act_n=1, A[16:14]=3'b010, bg/ba of the open bank.
- Deselect (every non-command cycle): cs_n all 1, act_n=1, A=0, bg=0, ba=0.
- Write burst: for BL consecutive cycles dq_oe=1, dq_out=beat i, dqs_t_out all 1, dqs_c_out all 0. This is a single-rate model with one beat per ck_t. Then WAIT_WR for TWR cycles, then PRE.
- Read burst: dq_in is sampled into beat i for BL consecutive cycles. rd_valid pulses the cycle after the last beat, and PRE issues in that same cycle.
- WAIT_RP lasts TRP cycles, then IDLE.
- Counters are sized $clog2(max timing param + BL)+1. They load on state entry and count down to the transition.

## Timing
Accept at cycle 0. Let C = 1+TRCD.
- ACT at cycle 1.
- RD/WR at cycle C.
- Write: dq_oe over cycles C+TCWL .. C+TCWL+BL-1. PRE at C+TCWL+BL+TWR.
- Read: samples over cycles C+TCL .. C+TCL+BL-1. rd_valid and PRE at C+TCL+BL.
- req_ready returns at PRE+TRP.
- Reset values: req_ready=0 during reset and 1 the cycle after, cs_n all 1, act_n=1, A/bg/ba=0, dq_oe=0, dq_out=0, dqs_t_out=0, dqs_c_out=0, rd_valid=0, rd_data=0.
- Reset mid-operation: return to IDLE next cycle. Burst aborted, no rd_valid, no PRE issued.
- req_valid held while not ready: ignored, no latch.

## Configuration
- OPEN_PAGE_EN defined: one open row (rank, bg, ba, row) is tracked.
  - After a burst, write recovery completes, then the FSM returns to IDLE without PRE; read goes directly to IDLE.
  - Hit (all four fields equal): RD/WR at accept+1.
  - Miss with open row: PRE (old bank) at accept+1, TRP wait, then the ACT sequence.
  - No open row: normal ACT sequence.
  - Reset clears the open-row valid flag.
- OPEN_PAGE_EN undefined: close-page. Every request is ACT→RD/WR→PRE, as in Timing.

## Test plan
- Reset: assert reset for 3 cycles mid-write burst → next cycle dq_oe=0, cs_n=all 1, req_ready=1 one cycle after release.
- Write rank0 bg1 ba1 row 1 col 0x10 accepted at cycle 0, defaults → ACT cycle 1 (A=1), WR cycle 16 (A=0x10010), dq_oe cycles 27–34 carrying beats 0–7, PRE cycle 47 (A=0x08000), req_ready cycle 62.
- Read same address, dq_in = beat index i in cycles 31–38 → rd_valid exactly at cycle 39, rd_data beat i = i, PRE cycle 39, req_ready cycle 54.
- req_valid held high for back-to-back reads → second accept exactly when req_ready returns, no overlap of commands.
- OPEN_PAGE_EN: read to row 5, then read to row 5 → second RD one cycle after accept, no ACT. Then read to row 6 → PRE at accept+1, ACT at accept+1+TRP+1.
- TRCD=TCL=TCWL=TWR=TRP=1 → sequence still legal, no two commands in the same cycle, beat counts exactly 8.

Source files
------------

// File: rtl/ddr4_cmd_sequencer_if.sv
// ddr4_cmd_sequencer_if
//   Host-side request/response bundle for ddr4_cmd_sequencer.
//   master : host that issues requests and consumes read bursts
//   slave  : the sequencer
//   req_valid/req_ready handshake; req_write, req_rank, req_bg, req_ba,
//   req_row, req_col, req_wdata qualify a request. rd_valid pulses once
//   per completed read with the whole burst on rd_data.
interface ddr4_cmd_sequencer_if #(
    parameter int RANKS     = 1,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int DQWIDTH   = 72,
    parameter int BL        = 8
);
    localparam int RW = (RANKS > 1) ? $clog2(RANKS) : 1;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [RW-1:0]           req_rank;
    logic [BGWIDTH-1:0]      req_bg;
    logic [BAWIDTH-1:0]      req_ba;
    logic [ADDRWIDTH-1:0]    req_row;
    logic [COLWIDTH-1:0]     req_col;
    logic [DQWIDTH*BL-1:0]   req_wdata;
    logic                    rd_valid;
    logic [DQWIDTH*BL-1:0]   rd_data;

    modport master (
        output req_valid, req_write, req_rank, req_bg, req_ba, req_row, req_col, req_wdata,
        input  req_ready, rd_valid, rd_data
    );
    modport slave (
        input  req_valid, req_write, req_rank, req_bg, req_ba, req_row, req_col, req_wdata,
        output req_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/ddr4_cmd_sequencer.sv
// ddr4_cmd_sequencer
//   Single-request DDR4 command sequencer. Accepts one read or write burst,
//   issues ACT, RD/WR and PRE with programmable spacing, drives DQ/DQS for
//   write bursts and captures DQ for read bursts (one beat per ck_t).
// Ports:
//   ck_t, reset           clock and synchronous active-high reset
//   host                  request/response interface (slave modport)
//   cs_n, act_n, A, bg, ba  command/address pins
//   dq_out, dq_oe, dq_in  data pins (dq_oe also qualifies DQS drive)
//   dqs_t_out, dqs_c_out  write strobes
// Build option:
//   OPEN_PAGE_EN  keep the last activated row open between requests
module ddr4_cmd_sequencer #(
    parameter int RANKS     = 1,
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int ADDRWIDTH = 17,
    parameter int COLWIDTH  = 10,
    parameter int DQWIDTH   = 72,
    parameter int DQSWIDTH  = 18,
    parameter int BL        = 8,
    parameter int TRCD      = 15,
    parameter int TCL       = 15,
    parameter int TCWL      = 11,
    parameter int TWR       = 12,
    parameter int TRP       = 15
) (
    input  logic                  ck_t,
    input  logic                  reset,
    ddr4_cmd_sequencer_if.slave   host,
    output logic [RANKS-1:0]      cs_n,
    output logic                  act_n,
    output logic [ADDRWIDTH-1:0]  A,
    output logic [BGWIDTH-1:0]    bg,
    output logic [BAWIDTH-1:0]    ba,
    output logic [DQWIDTH-1:0]    dq_out,
    output logic                  dq_oe,
    input  logic [DQWIDTH-1:0]    dq_in,
    output logic [DQSWIDTH-1:0]   dqs_t_out,
    output logic [DQSWIDTH-1:0]   dqs_c_out
);
    localparam int RW   = (RANKS > 1) ? $clog2(RANKS) : 1;
    localparam int M1   = (TRCD > TCL) ? TRCD : TCL;
    localparam int M2   = (TCWL > TWR) ? TCWL : TWR;
    localparam int M3   = (M1 > M2) ? M1 : M2;
    localparam int TMAX = (M3 > TRP) ? M3 : TRP;
    localparam int CW   = $clog2(TMAX + BL) + 1;
`ifdef OPEN_PAGE_EN
    localparam bit OPEN_PAGE = 1'b1;
`else
    localparam bit OPEN_PAGE = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, ACT, WAIT_RCD, CMD, WAIT_LAT, BURST, WAIT_WR, PRE, WAIT_RP
    } state_t;

    state_t                 state, st_nxt;
    logic [CW-1:0]          cnt, cnt_nxt, beat, lat_cyc;
    logic                   lat_wr, rd_vld, accept, pend_act;
    logic [RW-1:0]          lat_rank, pre_rank;
    logic [BGWIDTH-1:0]     lat_bg, pre_bg;
    logic [BAWIDTH-1:0]     lat_ba, pre_ba;
    logic [ADDRWIDTH-1:0]   lat_row;
    logic [COLWIDTH-1:0]    lat_col;
    logic [DQWIDTH*BL-1:0]  lat_wdata, rd_buf;

    assign host.req_ready = (state == IDLE) && !reset;
    assign host.rd_valid  = rd_vld;
    assign host.rd_data   = rd_buf;
    assign accept         = host.req_valid && host.req_ready;
    // cnt counts BL-1..0 through BURST, so the beat index runs upward
    assign beat           = CW'(BL - 1) - cnt;

`ifdef OPEN_PAGE_EN
    logic                   open_vld, hit;
    logic [RW-1:0]          open_rank;
    logic [BGWIDTH-1:0]     open_bg;
    logic [BAWIDTH-1:0]     open_ba;
    logic [ADDRWIDTH-1:0]   open_row;

    assign hit = open_vld && (open_rank == host.req_rank) && (open_bg == host.req_bg) &&
                 (open_ba == host.req_ba) && (open_row == host.req_row);
    // PRE only ever closes the tracked row (miss path)
    assign pre_rank = open_rank;
    assign pre_bg   = open_bg;
    assign pre_ba   = open_ba;

    always_ff @(posedge ck_t) begin
        if (reset) begin
            open_vld  <= 1'b0;
            pend_act  <= 1'b0;
            open_rank <= '0;
            open_bg   <= '0;
            open_ba   <= '0;
            open_row  <= '0;
        end else begin
            // pend_act: the PRE/WAIT_RP in flight must be followed by ACT
            if (accept) pend_act <= open_vld && !hit;
            if (state == ACT) begin
                pend_act  <= 1'b0;
                open_vld  <= 1'b1;
                open_rank <= lat_rank;
                open_bg   <= lat_bg;
                open_ba   <= lat_ba;
                open_row  <= lat_row;
            end
        end
    end
`else
    assign pend_act = 1'b0;
    assign pre_rank = lat_rank;
    assign pre_bg   = lat_bg;
    assign pre_ba   = lat_ba;
`endif

    always_ff @(posedge ck_t) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_vld    <= 1'b0;
            rd_buf    <= '0;
            lat_wr    <= 1'b0;
            lat_rank  <= '0;
            lat_bg    <= '0;
            lat_ba    <= '0;
            lat_row   <= '0;
            lat_col   <= '0;
            lat_wdata <= '0;
        end else begin
            state  <= st_nxt;
            cnt    <= cnt_nxt;
            rd_vld <= (state == BURST) && !lat_wr && (cnt == '0);
            if (accept) begin
                lat_wr    <= host.req_write;
                lat_rank  <= host.req_rank;
                lat_bg    <= host.req_bg;
                lat_ba    <= host.req_ba;
                lat_row   <= host.req_row;
                lat_col   <= host.req_col;
                lat_wdata <= host.req_wdata;
            end
            if (state == BURST && !lat_wr) rd_buf[beat*DQWIDTH +: DQWIDTH] <= dq_in;
        end
    end

    // Each wait state is skipped when its length is zero, so a timing
    // value of 1 puts commands on consecutive cycles.
    always_comb begin
        st_nxt  = state;
        cnt_nxt = (cnt != '0) ? cnt - CW'(1) : cnt;
        lat_cyc = lat_wr ? CW'(TCWL) : CW'(TCL);
        case (state)
            IDLE: if (accept) begin
`ifdef OPEN_PAGE_EN
                if (hit)           st_nxt = CMD;
                else if (open_vld) st_nxt = PRE;
                else               st_nxt = ACT;
`else
                st_nxt = ACT;
`endif
            end
            ACT: begin
                if (TRCD > 1) begin
                    st_nxt  = WAIT_RCD;
                    cnt_nxt = CW'(TRCD - 2);
                end else st_nxt = CMD;
            end
            WAIT_RCD: if (cnt == '0) st_nxt = CMD;
            CMD: begin
                if (lat_cyc > CW'(1)) begin
                    st_nxt  = WAIT_LAT;
                    cnt_nxt = lat_cyc - CW'(2);
                end else begin
                    st_nxt  = BURST;
                    cnt_nxt = CW'(BL - 1);
                end
            end
            WAIT_LAT: if (cnt == '0) begin
                st_nxt  = BURST;
                cnt_nxt = CW'(BL - 1);
            end
            BURST: if (cnt == '0) begin
                if (lat_wr) begin
                    st_nxt  = WAIT_WR;
                    cnt_nxt = CW'(TWR - 1);
                end else st_nxt = OPEN_PAGE ? IDLE : PRE;
            end
            WAIT_WR: if (cnt == '0) st_nxt = OPEN_PAGE ? IDLE : PRE;
            PRE: begin
                // ready returns TRP after PRE; a miss waits one more cycle before ACT
                if (pend_act) begin
                    st_nxt  = WAIT_RP;
                    cnt_nxt = CW'(TRP - 1);
                end else if (TRP > 1) begin
                    st_nxt  = WAIT_RP;
                    cnt_nxt = CW'(TRP - 2);
                end else st_nxt = IDLE;
            end
            WAIT_RP: if (cnt == '0) st_nxt = pend_act ? ACT : IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    always_comb begin
        cs_n      = '1;
        act_n     = 1'b1;
        A         = '0;
        bg        = '0;
        ba        = '0;
        dq_oe     = 1'b0;
        dq_out    = '0;
        dqs_t_out = '0;
        dqs_c_out = '0;
        case (state)
            ACT: begin
                cs_n[lat_rank] = 1'b0;
                act_n          = 1'b0;
                A              = lat_row;
                bg             = lat_bg;
                ba             = lat_ba;
            end
            CMD: begin
                cs_n[lat_rank]    = 1'b0;
                A[COLWIDTH-1:0]   = lat_col;
                A[16:14]          = lat_wr ? 3'b100 : 3'b101;
                bg                = lat_bg;
                ba                = lat_ba;
            end
            PRE: begin
                cs_n[pre_rank] = 1'b0;
                A[16:14]       = 3'b010;
                bg             = pre_bg;
                ba             = pre_ba;
            end
            BURST: if (lat_wr) begin
                dq_oe     = 1'b1;
                dq_out    = lat_wdata[beat*DQWIDTH +: DQWIDTH];
                dqs_t_out = '1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ddr4_cmd_sequencer.sv
// tb_ddr4_cmd_sequencer
//   Directed bench for ddr4_cmd_sequencer. dut1 uses default timing,
//   dut2 uses all timing parameters = 1. A negedge monitor logs commands,
//   write beats, read completions and req_ready rises relative to the
//   accept cycle of the last request; each test task checks those logs.
module tb_ddr4_cmd_sequencer;
    logic ck_t = 1'b0;
    logic reset = 1'b1;
    always #5 ck_t = ~ck_t;

    typedef struct {int c; logic act; logic [16:0] a; logic [1:0] bg; logic [1:0] ba;} cmd_t;

    int ncmp = 0, nerr = 0, cyc = 0, t0 = 0, dqs_bad = 0;
    bit sel = 1'b0;
    logic v_valid = 1'b0, v_write = 1'b0;
    logic [1:0] v_bg = '0, v_ba = '0;
    logic [16:0] v_row = '0;
    logic [9:0] v_col = '0;
    logic [575:0] v_wdata = '0;
    logic [71:0] dq_in = '0;
    logic rdy, prev_rdy;

    cmd_t cmd_q[$];
    int dq_c[$], rv_c[$], rdy_c[$];
    logic [71:0] dq_d[$];
    logic [575:0] rv_d[$];

    logic [0:0]  cs_n1, cs_n2;
    logic        act_n1, act_n2, dq_oe1, dq_oe2;
    logic [16:0] A1, A2;
    logic [1:0]  bg1, bg2, ba1, ba2;
    logic [71:0] dq_out1, dq_out2;
    logic [17:0] dqs_t1, dqs_t2, dqs_c1, dqs_c2;

    ddr4_cmd_sequencer_if h1();
    ddr4_cmd_sequencer_if h2();
    assign h1.req_valid = v_valid & ~sel;
    assign h2.req_valid = v_valid & sel;
    assign h1.req_write = v_write;  assign h2.req_write = v_write;
    assign h1.req_rank  = 1'b0;     assign h2.req_rank  = 1'b0;
    assign h1.req_bg    = v_bg;     assign h2.req_bg    = v_bg;
    assign h1.req_ba    = v_ba;     assign h2.req_ba    = v_ba;
    assign h1.req_row   = v_row;    assign h2.req_row   = v_row;
    assign h1.req_col   = v_col;    assign h2.req_col   = v_col;
    assign h1.req_wdata = v_wdata;  assign h2.req_wdata = v_wdata;

    ddr4_cmd_sequencer dut1 (
        .ck_t(ck_t), .reset(reset), .host(h1), .cs_n(cs_n1), .act_n(act_n1), .A(A1),
        .bg(bg1), .ba(ba1), .dq_out(dq_out1), .dq_oe(dq_oe1), .dq_in(dq_in),
        .dqs_t_out(dqs_t1), .dqs_c_out(dqs_c1)
    );
    ddr4_cmd_sequencer #(.TRCD(1), .TCL(1), .TCWL(1), .TWR(1), .TRP(1)) dut2 (
        .ck_t(ck_t), .reset(reset), .host(h2), .cs_n(cs_n2), .act_n(act_n2), .A(A2),
        .bg(bg2), .ba(ba2), .dq_out(dq_out2), .dq_oe(dq_oe2), .dq_in(dq_in),
        .dqs_t_out(dqs_t2), .dqs_c_out(dqs_c2)
    );

    always @(posedge ck_t) cyc <= cyc + 1;

    always @(negedge ck_t) begin
        if ((sel ? cs_n2[0] : cs_n1[0]) === 1'b0)
            cmd_q.push_back('{cyc - t0, sel ? act_n2 : act_n1, sel ? A2 : A1,
                              sel ? bg2 : bg1, sel ? ba2 : ba1});
        if ((sel ? dq_oe2 : dq_oe1) === 1'b1) begin
            dq_c.push_back(cyc - t0);
            dq_d.push_back(sel ? dq_out2 : dq_out1);
            if ((sel ? dqs_t2 : dqs_t1) !== '1 || (sel ? dqs_c2 : dqs_c1) !== '0) dqs_bad++;
        end
        if ((sel ? h2.rd_valid : h1.rd_valid) === 1'b1) begin
            rv_c.push_back(cyc - t0);
            rv_d.push_back(sel ? h2.rd_data : h1.rd_data);
        end
        rdy = sel ? h2.req_ready : h1.req_ready;
        if (rdy === 1'b1 && prev_rdy !== 1'b1) rdy_c.push_back(cyc - t0);
        prev_rdy = rdy;
    end

    task automatic tick();
        @(negedge ck_t);
        #1;
    endtask

    function automatic logic [71:0] wbeat(input int i);
        return {8'hC0 + 8'(i), 64'h0123_4567_89AB_CDE0 + 64'(i)};
    endfunction

    task automatic send(input bit s, input bit w, input logic [1:0] g, input logic [1:0] b,
                        input logic [16:0] row, input logic [9:0] col);
        int n = 0;
        sel = s;
        tick();
        while ((s ? h2.req_ready : h1.req_ready) !== 1'b1 && n < 200) begin tick(); n++; end
        ncmp++;
        if (n >= 200) begin nerr++; $display("FAIL send_ready_timeout got=0 want=1"); end
        v_write = w; v_bg = g; v_ba = b; v_row = row; v_col = col;
        v_valid = 1'b1;
        t0 = cyc;
        cmd_q.delete(); dq_c.delete(); dq_d.delete(); rv_c.delete(); rv_d.delete(); rdy_c.delete();
        dqs_bad = 0;
    endtask

    // k counts cycles after the accept cycle; read beats go out at k=dqb..dqb+7
    task automatic run(input int n, input int dqb, input int hold);
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k > hold) v_valid = 1'b0;
            dq_in = (dqb > 0 && k >= dqb && k < dqb + 8) ? 72'(k - dqb) : {9{8'hEE}};
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            tick();
            ncmp++;
            if (h1.req_ready !== 1'b0 || cs_n1 !== 1'b1 || act_n1 !== 1'b1 || A1 !== '0 ||
                bg1 !== '0 || ba1 !== '0 || dq_oe1 !== 1'b0 || dq_out1 !== '0 ||
                dqs_t1 !== '0 || dqs_c1 !== '0 || h1.rd_valid !== 1'b0 || h1.rd_data !== '0) begin
                nerr++;
                $display("FAIL rst_values ready=%b cs_n=%b act_n=%b A=%h dq_oe=%b rd_valid=%b want 0/1/1/0/0/0",
                         h1.req_ready, cs_n1, act_n1, A1, dq_oe1, h1.rd_valid);
            end
        end
        reset = 1'b0;
        tick();
        ncmp++;
        if (h1.req_ready !== 1'b1 || h2.req_ready !== 1'b1) begin
            nerr++; $display("FAIL rst_ready_after got=%b/%b want=1/1", h1.req_ready, h2.req_ready);
        end
        // reset in the middle of a write burst
        for (int i = 0; i < 8; i++) v_wdata[i*72 +: 72] = wbeat(i);
        send(0, 1'b1, 2'd1, 2'd1, 17'd1, 10'h10);
        run(30, 0, 0);
        reset = 1'b1;
        tick();
        ncmp++;
        if (dq_oe1 !== 1'b0 || cs_n1 !== 1'b1 || h1.req_ready !== 1'b0) begin
            nerr++; $display("FAIL rst_mid dq_oe=%b cs_n=%b ready=%b want 0/1/0", dq_oe1, cs_n1, h1.req_ready);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        ncmp++;
        if (h1.req_ready !== 1'b1) begin nerr++; $display("FAIL rst_mid_ready got=%b want=1", h1.req_ready); end
        run(60, 0, 0);
        ncmp++;
        if (cmd_q.size() != 2 || dq_c.size() != 4 || rv_c.size() != 0) begin
            nerr++; $display("FAIL rst_abort cmds=%0d beats=%0d rdv=%0d want 2/4/0",
                             cmd_q.size(), dq_c.size(), rv_c.size());
        end
    endtask

    task automatic test_write();
        int ec[3] = '{1, 16, 47};
        logic [16:0] ea[3] = '{17'h00001, 17'h10010, 17'h08000};
        logic eact[3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) v_wdata[i*72 +: 72] = wbeat(i);
        send(0, 1'b1, 2'd1, 2'd1, 17'd1, 10'h10);
        run(70, 0, 0);
        ncmp++;
        if (cmd_q.size() != 3) begin nerr++; $display("FAIL wr_cmd_count got=%0d want=3", cmd_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            ncmp++;
            if (cmd_q[i].c != ec[i] || cmd_q[i].a !== ea[i] || cmd_q[i].act !== eact[i] ||
                cmd_q[i].bg !== 2'd1 || cmd_q[i].ba !== 2'd1) begin
                nerr++; $display("FAIL wr_cmd%0d got cyc=%0d A=%h act_n=%b want cyc=%0d A=%h act_n=%b",
                                 i, cmd_q[i].c, cmd_q[i].a, cmd_q[i].act, ec[i], ea[i], eact[i]);
            end
        end
        ncmp++;
        if (dq_c.size() != 8) begin nerr++; $display("FAIL wr_beat_count got=%0d want=8", dq_c.size()); end
        else for (int i = 0; i < 8; i++) begin
            ncmp++;
            if (dq_c[i] != 27 + i || dq_d[i] !== wbeat(i)) begin
                nerr++; $display("FAIL wr_beat%0d got cyc=%0d dq=%h want cyc=%0d dq=%h",
                                 i, dq_c[i], dq_d[i], 27 + i, wbeat(i));
            end
        end
        ncmp++;
        if (dqs_bad != 0) begin nerr++; $display("FAIL wr_dqs bad_beats=%0d want=0", dqs_bad); end
        ncmp++;
        if (rdy_c.size() != 1 || rdy_c[0] != 62) begin
            nerr++; $display("FAIL wr_ready got n=%0d first=%0d want n=1 cyc=62",
                             rdy_c.size(), (rdy_c.size() > 0) ? rdy_c[0] : -1);
        end
    endtask

    task automatic test_read();
        int ec[3] = '{1, 16, 39};
        logic [16:0] ea[3] = '{17'h00001, 17'h14010, 17'h08000};
        send(0, 1'b0, 2'd1, 2'd1, 17'd1, 10'h10);
        run(60, 31, 0);
        ncmp++;
        if (cmd_q.size() != 3) begin nerr++; $display("FAIL rd_cmd_count got=%0d want=3", cmd_q.size()); end
        else for (int i = 0; i < 3; i++) begin
            ncmp++;
            if (cmd_q[i].c != ec[i] || cmd_q[i].a !== ea[i]) begin
                nerr++; $display("FAIL rd_cmd%0d got cyc=%0d A=%h want cyc=%0d A=%h",
                                 i, cmd_q[i].c, cmd_q[i].a, ec[i], ea[i]);
            end
        end
        ncmp++;
        if (rv_c.size() != 1 || rv_c[0] != 39) begin
            nerr++; $display("FAIL rd_valid got n=%0d want n=1 at cyc 39", rv_c.size());
        end else for (int i = 0; i < 8; i++) begin
            ncmp++;
            if (rv_d[0][i*72 +: 72] !== 72'(i)) begin
                nerr++; $display("FAIL rd_beat%0d got=%h want=%h", i, rv_d[0][i*72 +: 72], 72'(i));
            end
        end
        ncmp++;
        if (dq_c.size() != 0 || rdy_c.size() != 1 || rdy_c[0] != 54) begin
            nerr++; $display("FAIL rd_ready got beats=%0d n=%0d want beats=0 ready cyc=54",
                             dq_c.size(), rdy_c.size());
        end
    endtask

    task automatic test_back_to_back();
        int ec[6] = '{1, 16, 39, 55, 70, 93};
        send(0, 1'b0, 2'd2, 2'd3, 17'h1ABCD, 10'h3FF);
        run(120, 31, 60);
        ncmp++;
        if (cmd_q.size() != 6) begin nerr++; $display("FAIL b2b_cmd_count got=%0d want=6", cmd_q.size()); end
        else for (int i = 0; i < 6; i++) begin
            ncmp++;
            if (cmd_q[i].c != ec[i] || cmd_q[i].bg !== 2'd2 || cmd_q[i].ba !== 2'd3) begin
                nerr++; $display("FAIL b2b_cmd%0d got cyc=%0d bg=%0d ba=%0d want cyc=%0d bg=2 ba=3",
                                 i, cmd_q[i].c, cmd_q[i].bg, cmd_q[i].ba, ec[i]);
            end
        end
        ncmp++;
        if (rv_c.size() != 2 || rv_c[0] != 39 || rv_c[1] != 93) begin
            nerr++; $display("FAIL b2b_rd_valid got n=%0d want n=2 at 39,93", rv_c.size());
        end
        ncmp++;
        if (rdy_c.size() != 2 || rdy_c[0] != 54 || rdy_c[1] != 108) begin
            nerr++; $display("FAIL b2b_ready got n=%0d want n=2 at 54,108", rdy_c.size());
        end
    endtask

    task automatic test_fast();
        for (int i = 0; i < 8; i++) v_wdata[i*72 +: 72] = wbeat(7 - i);
        send(1, 1'b1, 2'd0, 2'd2, 17'h00123, 10'h005);
        run(20, 0, 0);
        ncmp++;
        if (cmd_q.size() != 3 || cmd_q[0].c != 1 || cmd_q[1].c != 2 || cmd_q[2].c != 12 ||
            cmd_q[1].a !== 17'h10005 || cmd_q[2].a !== 17'h08000) begin
            nerr++; $display("FAIL fast_wr_cmds got n=%0d want ACT@1 WR@2 PRE@12", cmd_q.size());
        end
        ncmp++;
        if (dq_c.size() != 8 || dq_c[0] != 3 || dq_c[7] != 10 || dq_d[0] !== wbeat(7) || dq_d[7] !== wbeat(0)) begin
            nerr++; $display("FAIL fast_wr_beats got n=%0d want 8 beats at 3..10", dq_c.size());
        end
        ncmp++;
        if (rdy_c.size() != 1 || rdy_c[0] != 13) begin
            nerr++; $display("FAIL fast_wr_ready got n=%0d want cyc 13", rdy_c.size());
        end
        send(1, 1'b0, 2'd0, 2'd2, 17'h00123, 10'h005);
        run(20, 3, 0);
        ncmp++;
        if (cmd_q.size() != 3 || cmd_q[0].c != 1 || cmd_q[1].c != 2 || cmd_q[2].c != 11 ||
            cmd_q[1].a !== 17'h14005) begin
            nerr++; $display("FAIL fast_rd_cmds got n=%0d want ACT@1 RD@2 PRE@11", cmd_q.size());
        end
        ncmp++;
        if (rv_c.size() != 1 || rv_c[0] != 11 || rv_d[0][0 +: 72] !== 72'd0 || rv_d[0][7*72 +: 72] !== 72'd7) begin
            nerr++; $display("FAIL fast_rd_valid got n=%0d want one pulse at 11 beats 0..7", rv_c.size());
        end
        ncmp++;
        if (rdy_c.size() != 1 || rdy_c[0] != 12) begin
            nerr++; $display("FAIL fast_rd_ready got n=%0d want cyc 12", rdy_c.size());
        end
    endtask

`ifdef OPEN_PAGE_EN
    task automatic test_open_page();
        send(0, 1'b0, 2'd1, 2'd0, 17'd5, 10'h020);
        run(45, 31, 0);
        ncmp++;
        if (cmd_q.size() != 2 || cmd_q[0].act !== 1'b0 || cmd_q[1].c != 16 || rv_c.size() != 1 || rv_c[0] != 39) begin
            nerr++; $display("FAIL op_first got cmds=%0d rdv=%0d want 2 cmds, rd_valid at 39", cmd_q.size(), rv_c.size());
        end
        send(0, 1'b0, 2'd1, 2'd0, 17'd5, 10'h021);
        run(30, 16, 0);
        ncmp++;
        if (cmd_q.size() != 1 || cmd_q[0].c != 1 || cmd_q[0].a !== 17'h14021 || cmd_q[0].act !== 1'b1) begin
            nerr++; $display("FAIL op_hit got cmds=%0d want single RD at 1", cmd_q.size());
        end
        send(0, 1'b0, 2'd1, 2'd0, 17'd6, 10'h022);
        run(60, 0, 0);
        ncmp++;
        if (cmd_q.size() != 3 || cmd_q[0].c != 1 || cmd_q[0].a !== 17'h08000 ||
            cmd_q[1].c != 17 || cmd_q[1].act !== 1'b0 || cmd_q[1].a !== 17'd6 || cmd_q[2].c != 32) begin
            nerr++; $display("FAIL op_miss got cmds=%0d want PRE@1 ACT@17 RD@32", cmd_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef OPEN_PAGE_EN
        test_open_page();
`else
        test_write();
        test_read();
        test_back_to_back();
        test_fast();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
